// File: rtl/mem_port_arbiter.sv
// Three-way arbiter (fetch, data, external) sharing one 8-bit memory port.
// Sequences IDLE -> ISSUE -> WAIT -> COMPLETE with d > x > f priority and fetch anti-starvation.
module mem_port_arbiter #(
    parameter int unsigned MEM_LATENCY  = 1,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       f_req,
    input  logic [7:0] f_addr,
    output logic       f_gnt,
    output logic       f_done,
    output logic [7:0] f_rdata,
    input  logic       d_req,
    input  logic       d_we,
    input  logic [7:0] d_addr,
    input  logic [7:0] d_wdata,
    output logic       d_gnt,
    output logic       d_done,
    output logic [7:0] d_rdata,
    input  logic       x_req,
    input  logic       x_we,
    input  logic [7:0] x_addr,
    input  logic [7:0] x_wdata,
    output logic       x_gnt,
    output logic       x_done,
    output logic [7:0] x_rdata,
    output logic [7:0] address,
    output logic [7:0] to_mem,
    input  logic [7:0] from_mem,
    output logic       mem_clock,
    output logic       mem_write,
    output logic       busy
);

    localparam int unsigned LAT_W = (MEM_LATENCY > 2) ? $clog2(MEM_LATENCY) : 1;
    localparam int unsigned STV_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_COMPLETE} state_t;
    typedef enum logic [1:0] {P_NONE, P_F, P_D, P_X} port_t;

    state_t           state_q, state_d;
    port_t            owner_q, owner_d, excl, pick;
    logic             we_q, we_d;
    logic [7:0]       addr_d, wdata_d;
    logic [LAT_W-1:0] lat_q, lat_d;
    logic [STV_W-1:0] starve_q, starve_d;
    logic             arb_en, f_ok, d_ok, x_ok;
    logic             mem_clock_d, mem_write_d, busy_d;
    logic             f_gnt_d, d_gnt_d, x_gnt_d, f_done_d, d_done_d, x_done_d;

    // State register and registered outputs
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            owner_q   <= P_NONE;
            we_q      <= 1'b0;
            lat_q     <= '0;
            starve_q  <= '0;
            address   <= 8'h00;
            to_mem    <= 8'h00;
            mem_clock <= 1'b0;
            mem_write <= 1'b0;
            busy      <= 1'b0;
            f_gnt     <= 1'b0;
            d_gnt     <= 1'b0;
            x_gnt     <= 1'b0;
            f_done    <= 1'b0;
            d_done    <= 1'b0;
            x_done    <= 1'b0;
            f_rdata   <= 8'h00;
            d_rdata   <= 8'h00;
            x_rdata   <= 8'h00;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            we_q      <= we_d;
            lat_q     <= lat_d;
            starve_q  <= starve_d;
            address   <= addr_d;
            to_mem    <= wdata_d;
            mem_clock <= mem_clock_d;
            mem_write <= mem_write_d;
            busy      <= busy_d;
            f_gnt     <= f_gnt_d;
            d_gnt     <= d_gnt_d;
            x_gnt     <= x_gnt_d;
            f_done    <= f_done_d;
            d_done    <= d_done_d;
            x_done    <= x_done_d;
            // from_mem is valid during COMPLETE; captured for loads only
            if (state_q == S_COMPLETE && !we_q) begin
                case (owner_q)
                    P_F:     f_rdata <= from_mem;
                    P_D:     d_rdata <= from_mem;
                    P_X:     x_rdata <= from_mem;
                    default: ;
                endcase
            end
        end
    end

    // Next state, arbitration and next output values
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        we_d     = we_q;
        addr_d   = address;
        wdata_d  = to_mem;
        lat_d    = lat_q;
        starve_d = starve_q;
        arb_en   = 1'b0;
        excl     = P_NONE;
        pick     = P_NONE;

        case (state_q)
            S_IDLE: arb_en = 1'b1;
            S_ISSUE: begin
                if (MEM_LATENCY > 1) begin
                    state_d = S_WAIT;
                    lat_d   = LAT_W'(MEM_LATENCY - 2);
                end else begin
                    state_d = S_COMPLETE;
                end
            end
            S_WAIT: begin
                if (lat_q == '0) state_d = S_COMPLETE;
                else             lat_d   = lat_q - LAT_W'(1);
            end
            S_COMPLETE: begin
                arb_en = 1'b1;
                excl   = owner_q;
            end
            default: state_d = S_IDLE;
        endcase

        // The port just served sits out one arbitration round
        f_ok = f_req && (excl != P_F);
        d_ok = d_req && (excl != P_D);
        x_ok = x_req && (excl != P_X);
        if (f_ok && (starve_q >= STV_W'(STARVE_LIMIT))) pick = P_F;
        else if (d_ok)                                 pick = P_D;
        else if (x_ok)                                 pick = P_X;
        else if (f_ok)                                 pick = P_F;

        if (arb_en) begin
            owner_d = pick;
            case (pick)
                P_F: begin
                    state_d = S_ISSUE;
                    we_d    = 1'b0;
                    addr_d  = f_addr;
                    wdata_d = 8'h00;
                end
                P_D: begin
                    state_d = S_ISSUE;
                    we_d    = d_we;
                    addr_d  = d_addr;
                    wdata_d = d_wdata;
                end
                P_X: begin
                    state_d = S_ISSUE;
                    we_d    = x_we;
                    addr_d  = x_addr;
                    wdata_d = x_wdata;
                end
                default: state_d = S_IDLE;
            endcase
        end

        if (!f_req || (arb_en && pick == P_F)) begin
            starve_d = '0;
        end else if (arb_en && (pick == P_D || pick == P_X)
                     && (starve_q < STV_W'(STARVE_LIMIT))) begin
            starve_d = starve_q + STV_W'(1);
        end

        mem_clock_d = (state_d == S_ISSUE);
        mem_write_d = (state_d == S_ISSUE) && we_d;
        busy_d      = (state_d != S_IDLE);
        f_gnt_d     = busy_d && (owner_d == P_F);
        d_gnt_d     = busy_d && (owner_d == P_D);
        x_gnt_d     = busy_d && (owner_d == P_X);
        f_done_d    = (state_d == S_COMPLETE) && (owner_d == P_F);
        d_done_d    = (state_d == S_COMPLETE) && (owner_d == P_D);
        x_done_d    = (state_d == S_COMPLETE) && (owner_d == P_X);
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: u_dut (MEM_LATENCY=1) covers fetch/store/load/contention/starvation,
// u_lat (MEM_LATENCY=3) covers the wait states and reset during WAIT.
module tb_mem_port_arbiter;

    logic       clock = 1'b0;
    logic       reset_n, rst_l_n;
    logic       f_req, d_req, d_we, x_req, x_we;
    logic [7:0] f_addr, d_addr, d_wdata, x_addr, x_wdata;
    logic       f_gnt, f_done, d_gnt, d_done, x_gnt, x_done;
    logic [7:0] f_rdata, d_rdata, x_rdata, address, to_mem, from_mem;
    logic       mem_clock, mem_write, busy;

    logic       l_x_req, l_x_we;
    logic [7:0] l_x_addr;
    logic       l_f_gnt, l_f_done, l_d_gnt, l_d_done, l_x_gnt, l_x_done;
    logic [7:0] l_f_rdata, l_d_rdata, l_x_rdata, l_address, l_to_mem;
    logic [7:0] l_s0, l_s1, l_from_mem;
    logic       l_mem_clock, l_mem_write, l_busy;

    logic [7:0] mem [256];
    bit [255:0] written;
    int         vectors = 0;
    int         miscompares = 0;
    logic [2:0] exp_g [5];

    always #5 clock = ~clock;

    // Unwritten locations read back as addr ^ 0xB5 (so 0x10 holds 0xA5)
    function automatic logic [7:0] pat(input logic [7:0] a);
        return a ^ 8'hB5;
    endfunction

    always @(posedge clock) begin
        if (mem_clock) begin
            if (mem_write) begin
                mem[address]     <= to_mem;
                written[address] <= 1'b1;
            end
            from_mem <= written[address] ? mem[address] : pat(address);
        end
    end

    // Three-stage read pipe: data valid three cycles after the strobe rises
    always @(posedge clock) begin
        l_s0       <= l_mem_clock ? pat(l_address) : 8'h00;
        l_s1       <= l_s0;
        l_from_mem <= l_s1;
    end

    mem_port_arbiter #(.MEM_LATENCY(1), .STARVE_LIMIT(4)) u_dut (
        .clock(clock), .reset_n(reset_n),
        .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_done(f_done), .f_rdata(f_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_done(d_done), .d_rdata(d_rdata),
        .x_req(x_req), .x_we(x_we), .x_addr(x_addr), .x_wdata(x_wdata),
        .x_gnt(x_gnt), .x_done(x_done), .x_rdata(x_rdata),
        .address(address), .to_mem(to_mem), .from_mem(from_mem),
        .mem_clock(mem_clock), .mem_write(mem_write), .busy(busy)
    );

    mem_port_arbiter #(.MEM_LATENCY(3), .STARVE_LIMIT(4)) u_lat (
        .clock(clock), .reset_n(rst_l_n),
        .f_req(1'b0), .f_addr(8'h00), .f_gnt(l_f_gnt), .f_done(l_f_done), .f_rdata(l_f_rdata),
        .d_req(1'b0), .d_we(1'b0), .d_addr(8'h00), .d_wdata(8'h00),
        .d_gnt(l_d_gnt), .d_done(l_d_done), .d_rdata(l_d_rdata),
        .x_req(l_x_req), .x_we(l_x_we), .x_addr(l_x_addr), .x_wdata(8'h00),
        .x_gnt(l_x_gnt), .x_done(l_x_done), .x_rdata(l_x_rdata),
        .address(l_address), .to_mem(l_to_mem), .from_mem(l_from_mem),
        .mem_clock(l_mem_clock), .mem_write(l_mem_write), .busy(l_busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset_n = 1'b0; rst_l_n = 1'b0;
        f_req = 0; f_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
        x_req = 0; x_we = 0; x_addr = 0; x_wdata = 0;
        l_x_req = 0; l_x_we = 0; l_x_addr = 0;
        tick(); tick();
        chk("reset_ctl", {busy, mem_clock, mem_write, f_gnt, d_gnt, x_gnt, f_done, d_done, x_done}, 64'h0);
        chk("reset_data", {address, to_mem, f_rdata, d_rdata, x_rdata}, 64'h0);
        chk("reset_lat", {l_busy, l_mem_clock, l_x_gnt, l_x_done, l_address}, 64'h0);
        reset_n = 1'b1; rst_l_n = 1'b1;
        tick();

        // Single fetch
        f_req = 1; f_addr = 8'h10;
        tick();
        chk("fetch_issue", {mem_clock, mem_write, f_gnt, d_gnt, x_gnt, busy}, 64'b101001);
        chk("fetch_addr", address, 8'h10);
        tick();
        chk("fetch_done", {f_done, d_done, x_done, mem_clock, mem_write, f_gnt}, 64'b100001);
        f_req = 0;
        tick();
        chk("fetch_rdata", {f_rdata, busy, f_done}, {8'hA5, 2'b00});

        // Store then load at the same address
        d_req = 1; d_we = 1; d_addr = 8'h20; d_wdata = 8'h3C;
        tick();
        chk("store_issue", {mem_clock, mem_write, d_gnt, address, to_mem}, {3'b111, 8'h20, 8'h3C});
        tick();
        chk("store_done", {f_done, d_done, x_done, mem_write}, 64'b0100);
        d_we = 0;
        tick();
        chk("store_no_rdata", {d_rdata, busy}, {8'h00, 1'b0});
        tick();
        chk("load_issue", {mem_clock, mem_write, d_gnt}, 64'b101);
        tick();
        chk("load_done", {f_done, d_done, x_done}, 64'b010);
        d_req = 0;
        tick();
        chk("load_rdata", d_rdata, 8'h3C);

        // Contention: all three request together -> d, x, f
        f_req = 1; f_addr = 8'h11; d_req = 1; d_we = 0; d_addr = 8'h40;
        x_req = 1; x_we = 0; x_addr = 8'h30;
        tick();
        chk("cont_gnt_d", {f_gnt, d_gnt, x_gnt}, 64'b010);
        tick();
        chk("cont_done_d", {f_done, d_done, x_done}, 64'b010);
        d_req = 0;
        tick();
        chk("cont_gnt_x", {f_gnt, d_gnt, x_gnt, mem_clock, address}, {4'b0011, 8'h30});
        chk("cont_d_rdata", d_rdata, 8'hF5);
        tick();
        chk("cont_done_x", {f_done, d_done, x_done}, 64'b001);
        x_req = 0;
        tick();
        chk("cont_gnt_f", {f_gnt, d_gnt, x_gnt}, 64'b100);
        tick();
        chk("cont_done_f", {f_done, d_done, x_done}, 64'b100);
        f_req = 0;
        tick();
        chk("cont_rdata", {f_rdata, x_rdata, busy}, {8'hA4, 8'h85, 1'b0});

        // Starvation: d and x hammer continuously; fetch forced after 4 grants
        exp_g = '{3'b010, 3'b001, 3'b010, 3'b001, 3'b100};
        f_req = 1; f_addr = 8'h12; d_req = 1; d_addr = 8'h41; x_req = 1; x_addr = 8'h31;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("starve_gnt%0d", i), {f_gnt, d_gnt, x_gnt, mem_clock}, {exp_g[i], 1'b1});
            if (i == 4) begin
                d_req = 0; x_req = 0;
            end
            tick();
            chk($sformatf("starve_done%0d", i), {f_done, d_done, x_done}, exp_g[i]);
        end
        f_req = 0;
        tick();
        chk("starve_rdata", {f_rdata, d_rdata, x_rdata, busy}, {8'hA7, 8'hF4, 8'h84, 1'b0});

        // Latency 3: done four cycles after the request, operands latched
        l_x_req = 1; l_x_addr = 8'h50;
        tick();
        chk("lat_issue", {l_mem_clock, l_x_gnt, l_address}, {2'b11, 8'h50});
        l_x_addr = 8'h99;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk($sformatf("lat_wait%0d", i), {l_mem_clock, l_x_done, l_x_gnt, l_busy, l_address},
                {4'b0011, 8'h50});
        end
        tick();
        chk("lat_done", {l_x_done, l_x_gnt, l_address}, {2'b11, 8'h50});
        l_x_req = 0;
        tick();
        chk("lat_rdata", {l_x_rdata, l_busy, l_x_done}, {8'hE5, 2'b00});

        // Reset during WAIT: outputs clear at once, no done, request replayed
        l_x_req = 1; l_x_addr = 8'h51;
        tick(); tick();
        chk("rst_pre_wait", {l_busy, l_mem_clock}, 64'b10);
        rst_l_n = 1'b0;
        #1;
        chk("rst_async", {l_busy, l_x_gnt, l_x_done, l_mem_clock, l_address, l_x_rdata}, 64'h0);
        tick();
        chk("rst_held", {l_busy, l_x_done}, 64'b00);
        rst_l_n = 1'b1;
        tick();
        chk("rst_reissue", {l_x_gnt, l_mem_clock, l_x_done, l_address}, {3'b110, 8'h51});
        for (int i = 0; i < 2; i++) begin
            tick();
            chk($sformatf("rst_wait%0d", i), {l_x_done, l_mem_clock}, 64'b00);
        end
        tick();
        chk("rst_done", l_x_done, 1'b1);
        l_x_req = 0;
        tick();
        chk("rst_rdata", l_x_rdata, 8'hE4);
        chk("lat_idle_ports", {l_f_gnt, l_f_done, l_d_gnt, l_d_done, l_f_rdata, l_d_rdata,
                               l_mem_write, l_to_mem}, 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
